// File: rtl/ram_1w2r_sync.sv
// ram_1w2r_sync
// Single-clock word RAM with one write port and two independent read ports:
// a 32-bit instruction fetch port and a full-width data read port.
//
// Each read port is a two-state req/gnt/valid/ack handshake. An accepted
// request loads a registered result one cycle later. The result stays stable
// until it is acknowledged. An address outside the mapped window
// [BASE_ADDR, BASE_ADDR + DEPTH*DATA_W/8) returns zero data with err set.
// A write outside that window is dropped.
//
// Optional build macro:
//   RAM_WR_FWD_EN  when defined, a read accepted in the same cycle as a write
//                  to the same word returns the merged post-write value.
//                  When undefined, that read returns the pre-write value
//                  (read-before-write).
//
// Parameters:
//   DATA_W     word width in bits, a multiple of 32
//   DEPTH      word count, a power of two, >= 2
//   BASE_ADDR  byte address of word 0
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   inst_addr/req/gnt/ack           instruction port handshake
//   inst/inst_valid/inst_err        32-bit lane result
//   ram_addr/ram_r_req/gnt/ack      data read port handshake
//   ram_r_data/valid/err            full-word result
//   ram_w_addr/ena/data/mask        write port, mask is a per-bit enable
//
// Read port FSM (one instance per port):
//   state | meaning
//   IDLE  | no result outstanding, gnt=1
//   HOLD  | result valid, held until ack; a new request is taken with ack
module ram_1w2r_sync #(
    parameter int          DATA_W    = 64,
    parameter int          DEPTH     = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [63:0]       inst_addr,
    input  logic              inst_req,
    output logic              inst_gnt,
    output logic [31:0]       inst,
    output logic              inst_valid,
    input  logic              inst_ack,
    output logic              inst_err,

    input  logic [63:0]       ram_addr,
    input  logic              ram_r_req,
    output logic              ram_r_gnt,
    output logic [DATA_W-1:0] ram_r_data,
    output logic              ram_r_valid,
    input  logic              ram_r_ack,
    output logic              ram_r_err,

    input  logic [63:0]       ram_w_addr,
    input  logic              ram_w_ena,
    input  logic [DATA_W-1:0] ram_w_data,
    input  logic [DATA_W-1:0] ram_w_mask
);

    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int LANES   = DATA_W / 32;
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } port_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic addr_ok(input logic [63:0] a);
        logic [63:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ((off >> BYTE_SH) < 64'(DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [63:0] a);
        logic [63:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> BYTE_SH);
    endfunction

    // ------------------------------------------------------------------
    // Write port
    // ------------------------------------------------------------------
    logic              w_fire;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_merged;

    // Writes are gated by rst_n so nothing lands while reset is held.
    assign w_fire   = ram_w_ena && addr_ok(ram_w_addr) && rst_n;
    assign w_idx    = addr_idx(ram_w_addr);
    assign w_merged = (mem[w_idx] & ~ram_w_mask) | (ram_w_data & ram_w_mask);

    always_ff @(posedge clk) begin
        if (w_fire) begin
            mem[w_idx] <= w_merged;
        end
    end

    // ------------------------------------------------------------------
    // Instruction port
    // ------------------------------------------------------------------
    port_state_t       i_state, i_state_nxt;
    logic              i_accept;
    logic              i_ok;
    logic [IDX_W-1:0]  i_idx;
    logic [DATA_W-1:0] i_word;
    logic [LANE_W-1:0] i_lane;
    logic [31:0]       i_lane_data;

    assign inst_valid = (i_state == HOLD);
    assign inst_gnt   = !inst_valid || inst_ack;
    assign i_accept   = inst_req && inst_gnt;
    assign i_ok       = addr_ok(inst_addr);
    assign i_idx      = addr_idx(inst_addr);
    assign i_lane     = (LANES > 1) ? inst_addr[2 +: LANE_W] : '0;

    always_comb begin
        i_word = mem[i_idx];
`ifdef RAM_WR_FWD_EN
        if (w_fire && (w_idx == i_idx)) begin
            i_word = w_merged;
        end
`endif
    end

    assign i_lane_data = i_word[{i_lane, 5'b0} +: 32];

    always_comb begin
        i_state_nxt = i_state;
        case (i_state)
            IDLE:    if (i_accept) i_state_nxt = HOLD;
            HOLD:    if (!i_accept && inst_ack) i_state_nxt = IDLE;
            default: i_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_state <= IDLE;
        end else begin
            i_state <= i_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst     <= '0;
            inst_err <= 1'b0;
        end else if (i_accept) begin
            inst     <= i_ok ? i_lane_data : 32'h0;
            inst_err <= !i_ok;
        end
    end

    // ------------------------------------------------------------------
    // Data read port
    // ------------------------------------------------------------------
    port_state_t       r_state, r_state_nxt;
    logic              r_accept;
    logic              r_ok;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_word;

    assign ram_r_valid = (r_state == HOLD);
    assign ram_r_gnt   = !ram_r_valid || ram_r_ack;
    assign r_accept    = ram_r_req && ram_r_gnt;
    assign r_ok        = addr_ok(ram_addr);
    assign r_idx       = addr_idx(ram_addr);

    always_comb begin
        r_word = mem[r_idx];
`ifdef RAM_WR_FWD_EN
        if (w_fire && (w_idx == r_idx)) begin
            r_word = w_merged;
        end
`endif
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            IDLE:    if (r_accept) r_state_nxt = HOLD;
            HOLD:    if (!r_accept && ram_r_ack) r_state_nxt = IDLE;
            default: r_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= r_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_r_data <= '0;
            ram_r_err  <= 1'b0;
        end else if (r_accept) begin
            ram_r_data <= r_ok ? r_word : '0;
            ram_r_err  <= !r_ok;
        end
    end

endmodule

// File: tb/tb_ram_1w2r_sync.sv
module tb_ram_1w2r_sync;

    localparam int          DW    = 64;
    localparam int          DEPTH = 64;
    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] OOR_HI = BASE + 64'(DEPTH * 8);
    localparam logic [63:0] OOR_LO = 64'h0000_0000_7FFF_FFF8;

    logic          clk;
    logic          rst_n;
    logic [63:0]   inst_addr;
    logic          inst_req;
    logic          inst_gnt;
    logic [31:0]   inst;
    logic          inst_valid;
    logic          inst_ack;
    logic          inst_err;
    logic [63:0]   ram_addr;
    logic          ram_r_req;
    logic          ram_r_gnt;
    logic [DW-1:0] ram_r_data;
    logic          ram_r_valid;
    logic          ram_r_ack;
    logic          ram_r_err;
    logic [63:0]   ram_w_addr;
    logic          ram_w_ena;
    logic [DW-1:0] ram_w_data;
    logic [DW-1:0] ram_w_mask;

    ram_1w2r_sync #(.DATA_W(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_addr(inst_addr), .inst_req(inst_req), .inst_gnt(inst_gnt),
        .inst(inst), .inst_valid(inst_valid), .inst_ack(inst_ack), .inst_err(inst_err),
        .ram_addr(ram_addr), .ram_r_req(ram_r_req), .ram_r_gnt(ram_r_gnt),
        .ram_r_data(ram_r_data), .ram_r_valid(ram_r_valid), .ram_r_ack(ram_r_ack),
        .ram_r_err(ram_r_err),
        .ram_w_addr(ram_w_addr), .ram_w_ena(ram_w_ena), .ram_w_data(ram_w_data),
        .ram_w_mask(ram_w_mask)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [63:0] d; logic e; } rsp_t;
    typedef struct packed { logic [31:0] d; logic e; } irsp_t;

    rsp_t        q_ram[$];
    irsp_t       q_inst[$];
    rsp_t        e_r;
    irsp_t       e_i;
    logic [63:0] model [int];
    int          total = 0;
    int          bad   = 0;

    function automatic bit in_rng(input logic [63:0] a);
        return (a >= BASE) && (((a - BASE) / 8) < 64'(DEPTH));
    endfunction

    function automatic int widx(input logic [63:0] a);
        return int'((a - BASE) / 8);
    endfunction

    function automatic logic [63:0] exp_word(input logic [63:0] a);
        if (!in_rng(a)) return 64'h0;
        if (!model.exists(widx(a))) return 64'h0;
        return model[widx(a)];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [63:0] a, input logic [63:0] d, input logic [63:0] m);
        logic [63:0] old;
        ram_w_addr = a; ram_w_data = d; ram_w_mask = m; ram_w_ena = 1'b1;
        tick();
        ram_w_ena = 1'b0;
        if (in_rng(a)) begin
            old = exp_word(a);
            model[widx(a)] = (old & ~m) | (d & m);
        end
    endtask

    task automatic issue_ram(input logic [63:0] a);
        ram_addr  = a;
        ram_r_req = 1'b1;
        q_ram.push_back('{d: exp_word(a), e: !in_rng(a)});
    endtask

    task automatic issue_inst(input logic [63:0] a);
        logic [63:0] w;
        w = exp_word(a);
        inst_addr = a;
        inst_req  = 1'b1;
        q_inst.push_back('{d: (a[2] ? w[63:32] : w[31:0]), e: !in_rng(a)});
    endtask

    task automatic idle_ports();
        ram_r_req = 1'b0; inst_req = 1'b0; ram_r_ack = 1'b1; inst_ack = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_inst_valid got=%b want=0", inst_valid); end
        total++; if (ram_r_valid !== 1'b0) begin bad++; $display("FAIL reset_ram_valid got=%b want=0", ram_r_valid); end
        total++; if (inst_err !== 1'b0 || ram_r_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b want=00", inst_err, ram_r_err); end
        total++; if (inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h want=0", inst); end
        total++; if (ram_r_data !== 64'h0) begin bad++; $display("FAIL reset_ram_data got=%h want=0", ram_r_data); end
        total++; if (inst_gnt !== 1'b1 || ram_r_gnt !== 1'b1) begin bad++; $display("FAIL reset_gnt got=%b%b want=11", inst_gnt, ram_r_gnt); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        write_word(BASE, 64'h1122_3344_5566_7788, '1);
        issue_inst(BASE + 64'd4);
        tick();
        inst_req = 1'b0;
        total++; if (inst_valid !== 1'b1 || inst !== 32'h1122_3344) begin bad++; $display("FAIL basic_upper_lane got=%b/%h want=1/11223344", inst_valid, inst); end
        e_i = q_inst.pop_front();
        total++; if (inst !== e_i.d || inst_err !== e_i.e) begin bad++; $display("FAIL basic_sb_inst got=%h/%b want=%h/%b", inst, inst_err, e_i.d, e_i.e); end
        issue_inst(BASE);
        issue_ram(BASE);
        tick();
        e_i = q_inst.pop_front();
        total++; if (inst_valid !== 1'b1 || inst !== e_i.d || inst_err !== e_i.e) begin bad++; $display("FAIL basic_lower_lane got=%b/%h/%b want=1/%h/%b", inst_valid, inst, inst_err, e_i.d, e_i.e); end
        e_r = q_ram.pop_front();
        total++; if (ram_r_valid !== 1'b1 || ram_r_data !== e_r.d || ram_r_err !== e_r.e) begin bad++; $display("FAIL basic_ram got=%b/%h/%b want=1/%h/%b", ram_r_valid, ram_r_data, ram_r_err, e_r.d, e_r.e); end
        idle_ports();
        total++; if (inst_valid !== 1'b0 || ram_r_valid !== 1'b0) begin bad++; $display("FAIL basic_ack_clears got=%b%b want=00", inst_valid, ram_r_valid); end
    endtask

    task automatic test_mask();
        write_word(BASE + 64'd8, 64'h0, '1);
        write_word(BASE + 64'd8, '1, 64'h0000_0000_FFFF_0000);
        issue_ram(BASE + 64'd8);
        issue_inst(BASE + 64'd8);
        tick();
        total++; if (ram_r_data !== 64'h0000_0000_FFFF_0000) begin bad++; $display("FAIL mask_const got=%h want=00000000ffff0000", ram_r_data); end
        e_r = q_ram.pop_front();
        total++; if (ram_r_valid !== 1'b1 || ram_r_data !== e_r.d || ram_r_err !== e_r.e) begin bad++; $display("FAIL mask_sb_ram got=%h/%b want=%h/%b", ram_r_data, ram_r_err, e_r.d, e_r.e); end
        e_i = q_inst.pop_front();
        total++; if (inst_valid !== 1'b1 || inst !== e_i.d || inst_err !== e_i.e) begin bad++; $display("FAIL mask_sb_inst got=%h/%b want=%h/%b", inst, inst_err, e_i.d, e_i.e); end
        idle_ports();
    endtask

    task automatic test_hold();
        logic [63:0] hv;
        logic [63:0] nd;
        write_word(BASE + 64'd24, 64'h0123_4567_89AB_CDEF, '1);
        ram_r_ack = 1'b0;
        issue_ram(BASE + 64'd24);
        tick();
        e_r = q_ram.pop_front();
        total++; if (ram_r_valid !== 1'b1 || ram_r_data !== e_r.d) begin bad++; $display("FAIL hold_first got=%b/%h want=1/%h", ram_r_valid, ram_r_data, e_r.d); end
        hv = e_r.d;
        ram_addr = BASE;
        nd = 64'h0;
        for (int i = 0; i < 3; i++) begin
            nd = {$urandom, $urandom};
            ram_w_addr = BASE + 64'd24; ram_w_data = nd; ram_w_mask = '1; ram_w_ena = 1'b1;
            total++; if (ram_r_gnt !== 1'b0) begin bad++; $display("FAIL hold_gnt cyc=%0d got=%b want=0", i, ram_r_gnt); end
            tick();
            total++; if (ram_r_valid !== 1'b1 || ram_r_data !== hv || ram_r_err !== 1'b0) begin bad++; $display("FAIL hold_stable cyc=%0d got=%b/%h/%b want=1/%h/0", i, ram_r_valid, ram_r_data, ram_r_err, hv); end
        end
        ram_w_ena = 1'b0;
        model[widx(BASE + 64'd24)] = nd;
        ram_r_req = 1'b0; ram_r_ack = 1'b1;
        #1;
        total++; if (ram_r_gnt !== 1'b1) begin bad++; $display("FAIL hold_gnt_on_ack got=%b want=1", ram_r_gnt); end
        tick();
        total++; if (ram_r_valid !== 1'b0) begin bad++; $display("FAIL hold_release got=%b want=0", ram_r_valid); end
        issue_ram(BASE + 64'd24);
        tick();
        e_r = q_ram.pop_front();
        total++; if (ram_r_valid !== 1'b1 || ram_r_data !== e_r.d) begin bad++; $display("FAIL hold_newval got=%h want=%h", ram_r_data, e_r.d); end
        idle_ports();
    endtask

    task automatic test_back_to_back();
        logic [63:0] wd;
        for (int i = 0; i < 8; i++) write_word(BASE + 64'(8 * (40 + i)), {$urandom, $urandom}, '1);
        ram_r_ack = 1'b1; inst_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue_ram(BASE + 64'(8 * (40 + i)));
            issue_inst(BASE + 64'(8 * (47 - i) + 4 * (i % 2)));
            wd = {$urandom, $urandom};
            ram_w_addr = BASE + 64'(8 * (56 + i)); ram_w_data = wd; ram_w_mask = '1; ram_w_ena = 1'b1;
            if (i > 0) begin
                total++; if (ram_r_gnt !== 1'b1 || inst_gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt i=%0d got=%b%b want=11", i, ram_r_gnt, inst_gnt); end
            end
            tick();
            model[56 + i] = wd;
            e_r = q_ram.pop_front();
            total++; if (ram_r_valid !== 1'b1 || ram_r_data !== e_r.d || ram_r_err !== e_r.e) begin bad++; $display("FAIL b2b_ram i=%0d got=%b/%h want=1/%h", i, ram_r_valid, ram_r_data, e_r.d); end
            e_i = q_inst.pop_front();
            total++; if (inst_valid !== 1'b1 || inst !== e_i.d || inst_err !== e_i.e) begin bad++; $display("FAIL b2b_inst i=%0d got=%b/%h want=1/%h", i, inst_valid, inst, e_i.d); end
        end
        ram_w_ena = 1'b0;
        idle_ports();
        total++; if (ram_r_valid !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b%b want=00", ram_r_valid, inst_valid); end
        issue_ram(BASE + 64'(8 * 57));
        tick();
        e_r = q_ram.pop_front();
        total++; if (ram_r_data !== e_r.d) begin bad++; $display("FAIL b2b_concurrent_wr got=%h want=%h", ram_r_data, e_r.d); end
        idle_ports();
    endtask

    task automatic test_fwd();
        logic [63:0] exp_r;
        logic [31:0] exp_i;
`ifdef RAM_WR_FWD_EN
        exp_r = 64'hA5;
        exp_i = 32'hDEAD_BEEF;
`else
        exp_r = 64'h5A;
        exp_i = 32'h0;
`endif
        write_word(BASE + 64'd16, 64'h5A, '1);
        ram_w_addr = BASE + 64'd16; ram_w_data = 64'hA5; ram_w_mask = '1; ram_w_ena = 1'b1;
        ram_addr = BASE + 64'd16; ram_r_req = 1'b1;
        q_ram.push_back('{d: exp_r, e: 1'b0});
        tick();
        ram_r_req = 1'b0;
        model[2] = 64'hA5;
        e_r = q_ram.pop_front();
        total++; if (ram_r_valid !== 1'b1 || ram_r_data !== e_r.d) begin bad++; $display("FAIL fwd_ram got=%h want=%h", ram_r_data, e_r.d); end
        ram_w_data = 64'hDEAD_BEEF_0000_0000; ram_w_mask = 64'hFFFF_FFFF_0000_0000;
        inst_addr = BASE + 64'd20; inst_req = 1'b1;
        q_inst.push_back('{d: exp_i, e: 1'b0});
        tick();
        inst_req = 1'b0; ram_w_ena = 1'b0;
        model[2] = 64'hDEAD_BEEF_0000_00A5;
        e_i = q_inst.pop_front();
        total++; if (inst_valid !== 1'b1 || inst !== e_i.d) begin bad++; $display("FAIL fwd_inst_masked got=%h want=%h", inst, e_i.d); end
        issue_ram(BASE + 64'd16);
        tick();
        total++; if (ram_r_data !== 64'hDEAD_BEEF_0000_00A5) begin bad++; $display("FAIL fwd_after got=%h want=deadbeef000000a5", ram_r_data); end
        e_r = q_ram.pop_front();
        idle_ports();
    endtask

    task automatic test_oor();
        write_word(BASE + 64'(8 * (DEPTH - 1)), 64'hCAFE_F00D_0000_0001, '1);
        issue_ram(OOR_LO);
        issue_inst(OOR_HI + 64'd4);
        tick();
        total++; if (ram_r_valid !== 1'b1 || ram_r_err !== 1'b1 || ram_r_data !== 64'h0) begin bad++; $display("FAIL oor_lo_ram got=%b/%b/%h want=1/1/0", ram_r_valid, ram_r_err, ram_r_data); end
        e_r = q_ram.pop_front();
        e_i = q_inst.pop_front();
        total++; if (inst_valid !== 1'b1 || inst !== e_i.d || inst_err !== e_i.e) begin bad++; $display("FAIL oor_hi_inst got=%b/%h/%b want=1/%h/%b", inst_valid, inst, inst_err, e_i.d, e_i.e); end
        issue_ram(OOR_HI);
        issue_inst(OOR_LO + 64'd4);
        tick();
        e_r = q_ram.pop_front();
        total++; if (ram_r_valid !== 1'b1 || ram_r_data !== e_r.d || ram_r_err !== e_r.e) begin bad++; $display("FAIL oor_hi_ram got=%h/%b want=%h/%b", ram_r_data, ram_r_err, e_r.d, e_r.e); end
        e_i = q_inst.pop_front();
        total++; if (inst !== e_i.d || inst_err !== e_i.e) begin bad++; $display("FAIL oor_lo_inst got=%h/%b want=%h/%b", inst, inst_err, e_i.d, e_i.e); end
        idle_ports();
        write_word(OOR_LO, '1, '1);
        write_word(OOR_HI, '1, '1);
        issue_ram(BASE + 64'(8 * (DEPTH - 1)));
        issue_inst(BASE);
        tick();
        total++; if (ram_r_data !== 64'hCAFE_F00D_0000_0001 || ram_r_err !== 1'b0) begin bad++; $display("FAIL oor_wr_top got=%h/%b want=cafef00d00000001/0", ram_r_data, ram_r_err); end
        total++; if (inst !== 32'h5566_7788 || inst_err !== 1'b0) begin bad++; $display("FAIL oor_wr_word0 got=%h/%b want=55667788/0", inst, inst_err); end
        e_r = q_ram.pop_front();
        e_i = q_inst.pop_front();
        idle_ports();
    endtask

    task automatic test_reset_inflight();
        write_word(BASE + 64'd40, 64'h55, '1);
        ram_addr = BASE + 64'd40; ram_r_req = 1'b1;
        inst_addr = BASE + 64'd40; inst_req = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        ram_r_req = 1'b0; inst_req = 1'b0;
        ram_w_addr = BASE + 64'd40; ram_w_data = 64'h99; ram_w_mask = '1; ram_w_ena = 1'b1;
        @(posedge clk);
        #1;
        total++; if (ram_r_valid !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL rstf_valid_in_reset got=%b%b want=00", ram_r_valid, inst_valid); end
        tick();
        ram_w_ena = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        total++; if (ram_r_valid !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL rstf_valid_after got=%b%b want=00", ram_r_valid, inst_valid); end
        total++; if (ram_r_data !== 64'h0 || inst !== 32'h0 || ram_r_err !== 1'b0 || inst_err !== 1'b0) begin bad++; $display("FAIL rstf_outputs got=%h/%h/%b%b want=0/0/00", ram_r_data, inst, ram_r_err, inst_err); end
        issue_ram(BASE + 64'd40);
        tick();
        e_r = q_ram.pop_front();
        total++; if (ram_r_valid !== 1'b1 || ram_r_data !== e_r.d) begin bad++; $display("FAIL rstf_wr_blocked got=%h want=%h", ram_r_data, e_r.d); end
        idle_ports();
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        inst_addr = '0; inst_req = 1'b0; inst_ack = 1'b1;
        ram_addr = '0; ram_r_req = 1'b0; ram_r_ack = 1'b1;
        ram_w_addr = '0; ram_w_ena = 1'b0; ram_w_data = '0; ram_w_mask = '0;
        test_reset();
        test_basic();
        test_mask();
        test_hold();
        test_back_to_back();
        test_fwd();
        test_oor();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_1w2r_sync.md
RAM_1W2R_SYNC -- requirements
Module: ram_1w2r_sync

Interface
REQ-001 SHALL have parameter DATA_W, default 64: word width in bits; multiple of 32.
REQ-002 SHALL have parameter DEPTH, default 4096: word count; power of two.
REQ-003 SHALL have parameter BASE_ADDR, default 64'h0000_0000_8000_0000: byte address of word 0.
REQ-004 SHALL have port clk, input, 1: single clock; all state on posedge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have inst port: inst_addr in 64, inst_req in 1, inst_gnt out 1, inst out 32, inst_valid out 1, inst_ack in 1, inst_err out 1.
REQ-007 SHALL have data read port: ram_addr in 64, ram_r_req in 1, ram_r_gnt out 1, ram_r_data out DATA_W, ram_r_valid out 1, ram_r_ack in 1, ram_r_err out 1.
REQ-008 SHALL have write port: ram_w_addr in 64, ram_w_ena in 1, ram_w_data in DATA_W, ram_w_mask in DATA_W (bit-enable).

Function
REQ-009 SHALL compute word index = (addr - BASE_ADDR) >> log2(DATA_W/8); in-range iff addr >= BASE_ADDR and index < DEPTH.
REQ-010 SHALL write in-range words on posedge with ram_w_ena=1: mem = (mem & ~mask) | (data & mask); out-of-range writes ignored.
REQ-011 SHALL, per read port, hold state IDLE/HOLD: gnt = !valid || ack; request accepted when req && gnt.
REQ-012 SHALL register accepted read result, asserting valid on the next cycle (latency 1).
REQ-013 SHALL, in HOLD (valid=1, ack=0), keep data, valid, err stable regardless of new writes or requests.
REQ-014 SHALL support back-to-back: valid && ack && req in same cycle loads new result, valid stays 1.
REQ-015 SHALL select inst = addr[2] ? word[63:32] : word[31:0] for DATA_W=64; generally the 32-bit lane given by addr bits [log2(DATA_W/8)-1:2].
REQ-016 SHALL, for out-of-range read, return data 0 and err=1 with valid=1; err=0 otherwise.
REQ-017 SHALL service both read ports and write independently in one cycle, no arbitration.
REQ-018 SHALL clear valid when ack=1 and no new accepted request.

Reset
REQ-019 SHALL, on rst_n=0, asynchronously force inst_valid, ram_r_valid, inst_err, ram_r_err to 0, inst and ram_r_data to 0, ports to IDLE.
REQ-020 SHALL not initialise memory contents on reset; writes blocked while rst_n=0.
REQ-021 SHALL discard an accepted read in flight when reset asserts mid-cycle; no valid after release.

Configuration
REQ-022 SHALL, with RAM_WR_FWD_EN defined, return on a read accepted in the same cycle as a write to the same in-range word the merged post-write value.
REQ-023 SHALL, without RAM_WR_FWD_EN, return the pre-write value in that case (read-before-write).

Verification
REQ-024 SHALL test: write 0x8000_0000 data 64'h1122334455667788 mask all-ones; next cycle inst_req addr 0x8000_0004 -> one cycle later inst_valid=1, inst=32'h11223344.
REQ-025 SHALL test: mask 64'h0000_0000_FFFF_0000 data all-ones on word 0x8000_0008 holding 0 -> read gives 64'h0000_0000_FFFF_0000.
REQ-026 SHALL test: ram_r_ack=0 for 3 cycles with write to held address -> ram_r_data unchanged, ram_r_gnt=0.
REQ-027 SHALL test: same-cycle write 64'hA5 and read of 0x8000_0010 (old 64'h5A) -> 64'hA5 with RAM_WR_FWD_EN, 64'h5A without.
REQ-028 SHALL test: read 0x7FFF_FFF8 and 0x8000_0000+DEPTH*8 -> valid=1, err=1, data 0; write there leaves memory unchanged.
REQ-029 SHALL test: rst_n low one cycle after accepted request -> valid stays 0, outputs 0 after release.
